filtr_sched: RTL and testbench

FILTR_SCHED -- requirements
Module: filtr_sched

---
 rtl/filtr_pkg.sv | 15 +
 rtl/filtr_sched.sv | 114 +++++++++++
 tb/tb_filtr_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/filtr_pkg.sv
// Shared definitions for the filter scheduler: FSM state encodings and drain length.
package filtr_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_DONE = 3'd2,
        CAPTURE   = 3'd3,
        DRAIN0    = 3'd4,
        DRAIN1    = 3'd5
    } state_t;

    localparam int unsigned DRAIN_LEN = 2;

endpackage

// File: rtl/filtr_sched.sv
// Schedules one sample at a time through an external filter, with timeout, overrun counting
// and coefficient updates deferred to IDLE.
module filtr_sched
    import filtr_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 24,
    parameter int unsigned COEF_SIZE = 25,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned OVR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 adc_valid,
    input  logic [DATA_SIZE-1:0] adc_data,
    output logic [DATA_SIZE-1:0] f_data_in,
    output logic                 f_sample_trig,
    input  logic                 f_filter_done,
    input  logic [DATA_SIZE-1:0] f_data_out,
    input  logic                 coef_wr,
    input  logic [COEF_SIZE-1:0] coef_in,
    output logic [COEF_SIZE-1:0] coef_out,
    output logic                 coef_pend,
    output logic [DATA_SIZE-1:0] dac_data,
    output logic                 dac_valid,
    output logic                 busy,
    output logic                 err_timeout,
    input  logic                 err_clr,
    output logic [OVR_W-1:0]     ovr_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [COEF_SIZE-1:0] coef_hold;
    logic                 apply_coef;

    assign busy       = (state != IDLE);
    assign apply_coef = (state == IDLE) && coef_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            coef_hold     <= '0;
            f_data_in     <= '0;
            f_sample_trig <= 1'b0;
            coef_out      <= '0;
            coef_pend     <= 1'b0;
            dac_data      <= '0;
            dac_valid     <= 1'b0;
            err_timeout   <= 1'b0;
            ovr_cnt       <= '0;
        end else begin
            f_sample_trig <= 1'b0;
            dac_valid     <= 1'b0;

            if (en && adc_valid && (state != IDLE) && (ovr_cnt != '1)) begin
                ovr_cnt <= ovr_cnt + 1'b1;
            end

            // A timeout set further down overrides this clear.
            if (err_clr) begin
                err_timeout <= 1'b0;
            end

            // A write landing on the application cycle stays pending with the new value.
            if (apply_coef) begin
                coef_out <= coef_hold;
            end
            if (coef_wr) begin
                coef_hold <= coef_in;
                coef_pend <= 1'b1;
            end else if (apply_coef) begin
                coef_pend <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (en && adc_valid) begin
                        f_data_in     <= adc_data;
                        f_sample_trig <= 1'b1;
                        state         <= TRIG;
                    end
                end
                TRIG: begin
                    wait_cnt <= '0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (f_filter_done) begin
                        state <= CAPTURE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    dac_data  <= f_data_out;
                    dac_valid <= 1'b1;
                    state     <= DRAIN0;
                end
                DRAIN0:  state <= DRAIN1;
                DRAIN1:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filtr_sched.sv
// Directed bench for filtr_sched: latency, overrun, timeout, coefficient handling, reset, enable.
module tb_filtr_sched;
    import filtr_pkg::*;

    localparam int unsigned DS = 24;
    localparam int unsigned CS = 25;
    localparam int unsigned TO = 15;
    localparam int unsigned OW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          adc_valid;
    logic [DS-1:0] adc_data;
    logic [DS-1:0] f_data_in;
    logic          f_sample_trig;
    logic          f_filter_done;
    logic [DS-1:0] f_data_out;
    logic          coef_wr;
    logic [CS-1:0] coef_in;
    logic [CS-1:0] coef_out;
    logic          coef_pend;
    logic [DS-1:0] dac_data;
    logic          dac_valid;
    logic          busy;
    logic          err_timeout;
    logic          err_clr;
    logic [OW-1:0] ovr_cnt;

    always #5 clk = ~clk;

    filtr_sched #(
        .DATA_SIZE(DS),
        .COEF_SIZE(CS),
        .TIMEOUT  (TO),
        .OVR_W    (OW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .f_data_in    (f_data_in),
        .f_sample_trig(f_sample_trig),
        .f_filter_done(f_filter_done),
        .f_data_out   (f_data_out),
        .coef_wr      (coef_wr),
        .coef_in      (coef_in),
        .coef_out     (coef_out),
        .coef_pend    (coef_pend),
        .dac_data     (dac_data),
        .dac_valid    (dac_valid),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr),
        .ovr_cnt      (ovr_cnt)
    );

    int n_total  = 0;
    int n_pass   = 0;
    int dv_cnt   = 0;
    int trig_cnt = 0;
    int dv0;
    int t0;

    always @(negedge clk) begin
        if (dac_valid) dv_cnt++;
        if (f_sample_trig) trig_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; adc_valid = 1'b0; adc_data = '0;
        f_filter_done = 1'b0; f_data_out = '0; coef_wr = 1'b0; coef_in = '0; err_clr = 1'b0;
        cyc(2);
        chk("rst_f_data_in", f_data_in, 0);
        chk("rst_trig", f_sample_trig, 0);
        chk("rst_coef_out", coef_out, 0);
        chk("rst_coef_pend", coef_pend, 0);
        chk("rst_dac_data", dac_data, 0);
        chk("rst_dac_valid", dac_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ovr", ovr_cnt, 0);
        reset = 1'b0;
        cyc(1);

        // Basic latency: accept at 0, trig at 1, done at 2, dac_valid at 4, idle at 6.
        en = 1'b1; adc_valid = 1'b1; adc_data = 24'h000100;
        cyc(1); adc_valid = 1'b0;
        chk("lat_trig", f_sample_trig, 1);
        chk("lat_f_data_in", f_data_in, 24'h000100);
        chk("lat_busy", busy, 1);
        cyc(1);
        chk("lat_trig_once", f_sample_trig, 0);
        f_filter_done = 1'b1; f_data_out = 24'h000080;
        cyc(1); f_filter_done = 1'b0;
        chk("lat_dv_early", dac_valid, 0);
        cyc(1);
        chk("lat_dv", dac_valid, 1);
        chk("lat_dac_data", dac_data, 24'h000080);
        cyc(1);
        chk("lat_dv_pulse", dac_valid, 0);
        chk("lat_hold_in", f_data_in, 24'h000100);
        cyc(DRAIN_LEN - 1);
        chk("lat_idle", busy, 0);

        // Overrun: second sample during CAPTURE is dropped.
        dv0 = dv_cnt; t0 = trig_cnt;
        adc_valid = 1'b1; adc_data = 24'h000200;
        cyc(1); adc_valid = 1'b0;
        cyc(1); f_filter_done = 1'b1; f_data_out = 24'h000055;
        cyc(1); f_filter_done = 1'b0; adc_valid = 1'b1; adc_data = 24'h000999;
        cyc(1); adc_valid = 1'b0;
        chk("ovr_one", ovr_cnt, 1);
        chk("ovr_dv", dac_valid, 1);
        chk("ovr_dac_data", dac_data, 24'h000055);
        chk("ovr_inflight", f_data_in, 24'h000200);
        cyc(2);
        chk("ovr_idle", busy, 0);
        chk("ovr_dv_count", dv_cnt - dv0, 1);
        chk("ovr_trig_count", trig_cnt - t0, 1);

        // Sustained violations must saturate, not wrap.
        adc_valid = 1'b1; f_filter_done = 1'b1;
        cyc(400);
        adc_valid = 1'b0; f_filter_done = 1'b0;
        cyc(20);
        chk("ovr_sat", ovr_cnt, 8'hFF);
        chk("ovr_sat_idle", busy, 0);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;

        // Timeout: trig at 1, err at 17, no output.
        dv0 = dv_cnt;
        adc_valid = 1'b1; adc_data = 24'h000300;
        cyc(1); adc_valid = 1'b0;
        chk("to_trig", f_sample_trig, 1);
        cyc(15);
        chk("to_not_yet", err_timeout, 0);
        chk("to_busy", busy, 1);
        cyc(1);
        chk("to_err", err_timeout, 1);
        chk("to_idle", busy, 0);
        chk("to_no_dv", dv_cnt - dv0, 0);
        err_clr = 1'b1;
        cyc(1); err_clr = 1'b0;
        chk("to_clr", err_timeout, 0);

        // Set wins over a simultaneous clear.
        adc_valid = 1'b1; err_clr = 1'b1;
        cyc(1); adc_valid = 1'b0;
        cyc(16);
        chk("to_set_prio", err_timeout, 1);
        cyc(1);
        chk("to_clr_after", err_timeout, 0);
        err_clr = 1'b0;

        // Coefficient write in IDLE applies after one pending cycle.
        coef_wr = 1'b1; coef_in = 25'h0000003;
        cyc(1); coef_wr = 1'b0;
        chk("coef_idle_pend", coef_pend, 1);
        cyc(1);
        chk("coef_idle_out", coef_out, 25'h0000003);
        chk("coef_idle_clr", coef_pend, 0);

        // Write while busy waits for IDLE.
        adc_valid = 1'b1; adc_data = 24'h000400;
        cyc(1); adc_valid = 1'b0; coef_wr = 1'b1; coef_in = 25'h0000010;
        cyc(1); coef_wr = 1'b0; f_filter_done = 1'b1;
        chk("coef_busy_pend", coef_pend, 1);
        chk("coef_busy_hold", coef_out, 25'h0000003);
        cyc(1); f_filter_done = 1'b0;
        cyc(3);
        chk("coef_busy_idle_hold", coef_out, 25'h0000003);
        cyc(1);
        chk("coef_busy_applied", coef_out, 25'h0000010);
        chk("coef_busy_pend_clr", coef_pend, 0);

        // Last write wins.
        adc_valid = 1'b1;
        cyc(1); adc_valid = 1'b0; coef_wr = 1'b1; coef_in = 25'h0000005;
        cyc(1); coef_in = 25'h0000007; f_filter_done = 1'b1;
        cyc(1); coef_wr = 1'b0; f_filter_done = 1'b0;
        cyc(4);
        chk("coef_last_wins", coef_out, 25'h0000007);

        // Write on the application cycle stays pending.
        coef_wr = 1'b1; coef_in = 25'h000000A;
        cyc(1); coef_in = 25'h000000B;
        cyc(1); coef_wr = 1'b0;
        chk("coef_same_out", coef_out, 25'h000000A);
        chk("coef_same_pend", coef_pend, 1);
        cyc(1);
        chk("coef_same_next", coef_out, 25'h000000B);
        chk("coef_same_clr", coef_pend, 0);

        // Application and acceptance in the same IDLE cycle.
        coef_wr = 1'b1; coef_in = 25'h000000C;
        cyc(1); coef_wr = 1'b0; adc_valid = 1'b1;
        cyc(1); adc_valid = 1'b0;
        chk("coef_acc_trig", f_sample_trig, 1);
        chk("coef_acc_out", coef_out, 25'h000000C);
        cyc(1); f_filter_done = 1'b1;
        cyc(1); f_filter_done = 1'b0;
        cyc(3);

        // Reset in WAIT_DONE clears everything at once.
        adc_valid = 1'b1; adc_data = 24'h000321;
        cyc(1); adc_valid = 1'b0; coef_wr = 1'b1; coef_in = 25'h000001F;
        cyc(1); coef_wr = 1'b0;
        dv0 = dv_cnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_f_data_in", f_data_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovr", ovr_cnt, 0);
        chk("mid_rst_pend", coef_pend, 0);
        chk("mid_rst_coef_out", coef_out, 0);
        chk("mid_rst_dac_data", dac_data, 0);
        chk("mid_rst_trig", f_sample_trig, 0);
        cyc(2); reset = 1'b0;
        chk("mid_rst_no_dv", dv_cnt - dv0, 0);
        cyc(1);
        adc_valid = 1'b1; adc_data = 24'h000654;
        cyc(1); adc_valid = 1'b0;
        chk("post_rst_trig", f_sample_trig, 1);
        cyc(1); f_filter_done = 1'b1; f_data_out = 24'h000777;
        cyc(1); f_filter_done = 1'b0;
        cyc(1);
        chk("post_rst_dv", dac_valid, 1);
        chk("post_rst_data", dac_data, 24'h000777);
        cyc(2);

        // en=0 ignores samples and does not count them.
        t0 = trig_cnt;
        en = 1'b0; adc_valid = 1'b1; adc_data = 24'h000111;
        cyc(1); adc_valid = 1'b0;
        chk("en0_busy", busy, 0);
        chk("en0_ovr", ovr_cnt, 0);
        cyc(1);
        chk("en0_no_trig", trig_cnt - t0, 0);
        chk("en0_data_hold", f_data_in, 24'h000654);

        // Dropping en mid-operation lets the in-flight sample finish.
        en = 1'b1; adc_valid = 1'b1; adc_data = 24'h000222;
        cyc(1); adc_valid = 1'b0; en = 1'b0;
        cyc(1); f_filter_done = 1'b1; f_data_out = 24'h000333; adc_valid = 1'b1;
        cyc(1); f_filter_done = 1'b0; adc_valid = 1'b0;
        cyc(1);
        chk("en_mid_dv", dac_valid, 1);
        chk("en_mid_data", dac_data, 24'h000333);
        chk("en_mid_ovr", ovr_cnt, 0);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
